// File: rtl/mdu_pkg.sv
// Shared CPU constants for the multiply/divide unit: MDop encodings, latencies, FSM states.
package mdu_pkg;
  localparam logic [3:0] MD_NONE  = 4'b0000;
  localparam logic [3:0] MD_MULT  = 4'b0001;
  localparam logic [3:0] MD_MULTU = 4'b0010;
  localparam logic [3:0] MD_DIV   = 4'b0011;
  localparam logic [3:0] MD_DIVU  = 4'b0100;
  localparam logic [3:0] MD_MTHI  = 4'b0101;
  localparam logic [3:0] MD_MTLO  = 4'b0110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mdu_state_e;
endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned 32-bit divider. Works on magnitudes so the
// 0x80000000 / -1 overflow case wraps to 0x80000000 with remainder 0.
module mdu_divider (
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_signed,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem,
  output logic        o_div0
);
  logic        w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b, w_den, w_q, w_r;

  // Sign-magnitude divide; quotient truncates toward zero, remainder follows dividend sign.
  always_comb begin
    w_neg_a = i_signed & i_dividend[31];
    w_neg_b = i_signed & i_divisor[31];
    w_mag_a = w_neg_a ? (32'd0 - i_dividend) : i_dividend;
    w_mag_b = w_neg_b ? (32'd0 - i_divisor)  : i_divisor;
    // Substitute 1 for a zero divisor so the result is never X; the top discards it.
    w_den   = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
    w_q     = w_mag_a / w_den;
    w_r     = w_mag_a % w_den;
    o_quot  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q) : w_q;
    o_rem   = w_neg_a ? (32'd0 - w_r) : w_r;
    o_div0  = (i_divisor == 32'd0);
  end
endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO. The result is
// computed at accept and held in pending registers; only the commit edge
// (when busy falls) is visible.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDop,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi_p, r_lo_p;
  logic [3:0]       r_op;
  logic             r_div0;

  logic        w_accept, w_is_mul, w_is_div, w_commit;
  logic [63:0] w_prod;
  logic [31:0] w_quot, w_rem;
  logic        w_div0;

  mdu_divider u_div (
    .i_dividend (A),
    .i_divisor  (B),
    .i_signed   (MDop == MD_DIV),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_div0     (w_div0)
  );

  // Operation decode and full 64-bit product (sign-extend for mult, zero-extend for multu).
  always_comb begin
    w_accept = start & (r_state == S_IDLE);
    w_is_mul = (MDop == MD_MULT) | (MDop == MD_MULTU);
    w_is_div = (MDop == MD_DIV)  | (MDop == MD_DIVU);
    if (MDop == MD_MULT)
      w_prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      w_prod = {32'd0, A} * {32'd0, B};
    w_commit = (r_state == S_BUSY) & (r_cnt == CNT_W'(1));
  end

  // Next-state logic: IDLE->BUSY on accepted mult/div, BUSY->IDLE on the last counted edge.
  always_comb begin
    w_state_nx = r_state;
    busy       = (r_state == S_BUSY);
    case (r_state)
      S_IDLE: if (w_accept && (w_is_mul || w_is_div)) w_state_nx = S_BUSY;
      S_BUSY: if (w_commit) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Latency counter, pending result and op latch, captured at accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hi_p <= '0;
      r_lo_p <= '0;
      r_op   <= MD_NONE;
      r_div0 <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_cnt  <= CNT_W'(MULT_CYCLES);
      r_hi_p <= w_prod[63:32];
      r_lo_p <= w_prod[31:0];
      r_op   <= MDop;
      r_div0 <= 1'b0;
    end else if (w_accept && w_is_div) begin
      r_cnt  <= CNT_W'(DIV_CYCLES);
      r_hi_p <= w_rem;
      r_lo_p <= w_quot;
      r_op   <= MDop;
      r_div0 <= w_div0;
    end else if (r_state == S_BUSY) begin
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Architectural HI/LO: direct moves when idle, pending result on commit unless divide-by-zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (w_commit) begin
      if (!r_div0) begin
        HI <= r_hi_p;
        LO <= r_lo_p;
      end
    end else if (w_accept && MDop == MD_MTHI) begin
      HI <= A;
    end else if (w_accept && MDop == MD_MTLO) begin
      LO <= A;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy length, and abort behaviour.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDop;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  mdu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDop(MDop),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue a mult/div op, check busy length and that HI/LO hold, then check commit.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int ncyc,
                        input logic [31:0] hi_e, input logic [31:0] lo_e);
    int n;
    logic held;
    A = a; B = b; MDop = op; start = 1'b1;
    step();
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    n = 0; held = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      if (HI !== exp_hi || LO !== exp_lo) held = 1'b0;
      n++;
      step();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(ncyc));
    chk({tag, "_hold"}, {31'd0, held}, 32'd1);
    chk({tag, "_hi"}, HI, hi_e);
    chk({tag, "_lo"}, LO, lo_e);
    exp_hi = hi_e; exp_lo = lo_e;
  endtask

  initial begin
    int n;
    reset = 1'b1; A = '0; B = '0; MDop = MD_NONE; start = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    step();
    reset = 1'b0;

    run_op("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // back-to-back: issued in the first busy=0 cycle
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("div_pos_neg", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'd1, 32'h7FFF_FFFC);

    // mthi then divide-by-zero: full latency, HI/LO untouched
    A = 32'h1234; MDop = MD_MTHI; start = 1'b1;
    step();
    start = 1'b0;
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    exp_hi = 32'h1234;
    run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, 32'h1234, 32'h7FFF_FFFC);

    // mtlo then unused op codes: no state change
    A = 32'h5555; MDop = MD_MTLO; start = 1'b1;
    step();
    chk("mtlo_lo", LO, 32'h5555);
    exp_lo = 32'h5555;
    A = 32'h9999; MDop = 4'b0111; start = 1'b1;
    step();
    MDop = MD_NONE;
    step();
    start = 1'b0;
    chk("unused_busy", {31'd0, busy}, 32'd0);
    chk("unused_hi", HI, 32'h1234);
    chk("unused_lo", LO, 32'h5555);

    // div 100/7 with an mtlo pulsed in busy cycle 3 (ignored)
    A = 32'd100; B = 32'd7; MDop = MD_DIV; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    A = 32'hAAAA; MDop = MD_MTLO; start = 1'b1;
    step();
    start = 1'b0;
    chk("mtlo_in_busy_lo", LO, 32'h5555);
    n = 0;
    while (busy && n < 30) begin
      n++;
      step();
    end
    chk("div_mtlo_busy_done", {31'd0, busy}, 32'd0);
    chk("div_mtlo_lo", LO, 32'd14);
    chk("div_mtlo_hi", HI, 32'd2);

    // mult aborted by an async reset in busy cycle 2
    A = 32'd5; B = 32'd5; MDop = MD_MULT; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("abort_nocommit_busy", {31'd0, busy}, 32'd0);
    chk("abort_nocommit_hi", HI, 32'd0);
    chk("abort_nocommit_lo", LO, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit for the pipelined CPU, sitting beside the combinational ALU in the EX stage. It accepts two 32-bit operands and an operation code on a single-cycle `start` pulse and reports `busy` for a fixed latency. It then commits the 64-bit result to architectural HI/LO registers, which also serve `mthi`/`mtlo` writes. The hazard unit stalls the pipeline on `busy`, and on `start` when a `mfhi`/`mflo` follows.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `A` in 32: operand 1 (rs); dividend for div.
- `B` in 32: operand 2 (rt); divisor for div.
- `MDop` in 4: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; others are no-op.
- `start` in 1: qualifies `MDop`, `A` and `B` for one cycle.
- `busy` out 1: operation in flight.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- Reset clears `busy`, `HI`, `LO`, the counter and the internal result to 0, taking effect immediately.
- `start` is accepted only when `busy`=0. It is ignored, whatever `MDop` is, while `busy`=1.
- mthi: `HI`←`A` at the accepting edge. mtlo: `LO`←`A` at the accepting edge. `busy` stays 0.
- mult: {HI,LO}←`$signed(A)*$signed(B)`, the full 64-bit product.
- multu: the same as mult, unsigned.
- div: LO←quotient truncated toward zero. HI←remainder, which takes the sign of the dividend.
  - A=0x80000000 with B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO←A/B, HI←A%B, unsigned.
- Divide by zero (B=0, div or divu): the op runs its full latency, then HI and LO stay unchanged.
- Operands are captured at the accepting edge. `A`/`B` changes while busy have no effect.
- The result may be computed at accept or iteratively. Only commit timing is architecturally visible.
- Unused `MDop` codes with `start`=1: no state change, `busy` stays 0.

## Timing
- Let edge E0 be the edge that samples `start`=1 and `busy`=0 with a mult/div op, and let N be `MULT_CYCLES` or `DIV_CYCLES`.
  - `busy`=1 from after E0 through the N-th following edge.
  - `busy` is therefore 1 for exactly N cycles.
- HI/LO update at the same edge where `busy` falls.
  - The first cycle with `busy`=0 shows the new HI/LO.
  - HI/LO hold their old values throughout busy.
- A back-to-back `start` is accepted in the first cycle with `busy`=0.
- mthi/mtlo latency is one edge, and the new value is visible the next cycle.
- Reset mid-operation aborts the op: `busy`=0 and HI=LO=0 immediately, with no later commit.
- A `start` asserted in the same cycle that reset deasserts is ignored only if `reset` is still high at the edge.

## Structure
- Shared CPU package holds:
  - the `MDop` encodings as named constants (`MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`);
  - the defaults for `MULT_CYCLES` and `DIV_CYCLES`.
- The state is a two-state FSM (IDLE, BUSY) with a down-counter sized for max(`MULT_CYCLES`, `DIV_CYCLES`), plus pending HI/LO and an op latch.
- One sub-module is natural: `mdu_divider`, a signed/unsigned 32-bit divider. It may be combinational or iterative, provided it finishes within `DIV_CYCLES`.

## Test plan
- Reset then mult with A=0xFFFFFFFE (−2) and B=3 → `busy`=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 on the 5th busy edge.
- div with A=−7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- divu A=7, B=0 after mthi with A=0x1234 → HI=0x1234 the next cycle. After the div, HI=0x1234 and LO is unchanged.
- div issued, then mtlo with A=0xAAAA pulsed in busy cycle 3 → the mtlo is ignored, and LO holds the quotient after commit.
- mult started, `reset` pulsed asynchronously in busy cycle 2 → `busy`, HI and LO are 0 at once, and no commit follows.
